fetch_queue: RTL and testbench

Dual-issue instruction fetch queue that sits directly upstream of the scheduling/control unit and replaces the static instruction store as the source of `instruction0`/`instruction1`. It issues in-order word requests to instruction memory, buffers returned words with their PCs in a circular FIFO, and presents the two oldest entries to the issue stage each cycle. It retires 0, 1 or 2 entries per cycle under the issue stage's freeze/dependency control, and supports a redirect (flush) that discards buffered and in-flight fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo_mem.sv | 31 +++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one synchronous write port and two
// combinational read ports presenting the two oldest entries.
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  fq_entry_t     i_wdata,
    input  logic [AW-1:0] i_raddr0,
    input  logic [AW-1:0] i_raddr1,
    output fq_entry_t     o_rdata0,
    output fq_entry_t     o_rdata1
);

    // Contents are qualified by the queue's count, so the array needs no reset.
    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: in-order word requests to instruction memory, a
// circular buffer of {pc, instr}, and retirement of up to two entries per cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    // Request handshake: a transfer happens on a rising edge where
    // imem_req_valid && imem_req_ready; valid never waits on ready.
    output logic         imem_req_valid,
    output logic [31:0]  imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_resp_valid,
    input  logic [31:0]  imem_resp_data,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    input  logic         freeze1,
    input  logic         freeze2,
    input  logic         dependency_on_ins2,
    output logic [31:0]  instruction0,
    output logic [31:0]  instruction1,
    output logic [31:0]  pc0,
    output logic [31:0]  pc1,
    output logic         valid0,
    output logic         valid1,
    output logic         nothing_filled,
    output fetch_state_t o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;

    logic          w_has_credit;
    logic          w_req_fire;
    logic          w_resp_tracked;
    logic          w_push;
    logic          w_pop0;
    logic          w_pop1;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_outstanding_next;
    logic [31:0]   w_flush_pc_aligned;
    logic [AW-1:0] w_rd_ptr_plus1;
    fq_entry_t     w_wr_entry;
    fq_entry_t     w_rd0;
    fq_entry_t     w_rd1;

    // Credit counts buffered plus in-flight words, so a response always has room.
    assign w_has_credit   = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_resp_tracked = imem_resp_valid && (r_outstanding != '0);
    assign w_push         = w_resp_tracked && (r_state == FETCH) && !flush;

    assign w_pop0 = valid0 && !freeze1;
    assign w_pop1 = w_pop0 && valid1 && !freeze2 && !dependency_on_ins2;

    assign w_count_next       = r_count + CW'(w_push) - CW'(w_pop0) - CW'(w_pop1);
    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_resp_tracked);
    assign w_flush_pc_aligned = flush_pc & ~32'h0000_0003;
    assign w_rd_ptr_plus1     = r_rd_ptr + AW'(1);
    assign w_wr_entry         = '{pc: r_resp_pc, instr: imem_resp_data};

    fetch_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .i_we     (w_push && !rst),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (w_wr_entry),
        .i_raddr0 (r_rd_ptr),
        .i_raddr1 (w_rd_ptr_plus1),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving DRAIN waits for every pre-redirect response to come back.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = (w_outstanding_next != '0) ? DRAIN : FETCH;
        end else begin
            case (r_state)
                FETCH:   w_state_next = FETCH;
                DRAIN:   w_state_next = (w_outstanding_next == '0) ? FETCH : DRAIN;
                default: w_state_next = FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = !rst && !flush && (r_state == FETCH) && w_has_credit;
        imem_req_addr  = r_fetch_pc;
        o_dbg_state    = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (flush) begin
                r_count    <= '0;
                r_rd_ptr   <= r_wr_ptr;
                r_fetch_pc <= w_flush_pc_aligned;
                r_resp_pc  <= w_flush_pc_aligned;
            end else begin
                r_count  <= w_count_next;
                r_rd_ptr <= r_rd_ptr + AW'(w_pop0) + AW'(w_pop1);
                if (w_push) begin
                    r_wr_ptr  <= r_wr_ptr + AW'(1);
                    r_resp_pc <= r_resp_pc + PC_STEP;
                end
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
            end
        end
    end

    assign valid0         = (r_count != '0);
    assign valid1         = (r_count >= CW'(2));
    assign nothing_filled = (r_count == '0);
    assign instruction0   = valid0 ? w_rd0.instr : NOP_INSTR;
    assign pc0            = valid0 ? w_rd0.pc    : 32'h0;
    assign instruction1   = valid1 ? w_rd1.instr : NOP_INSTR;
    assign pc1            = valid1 ? w_rd1.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order memory model returning
// address-as-data and a queue-based reference model of the fetch buffer.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef logic [163:0] vec_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         imem_req_valid;
    logic [31:0]  imem_req_addr;
    logic         imem_req_ready;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         flush;
    logic [31:0]  flush_pc;
    logic         freeze1;
    logic         freeze2;
    logic         dependency_on_ins2;
    logic [31:0]  instruction0;
    logic [31:0]  instruction1;
    logic [31:0]  pc0;
    logic [31:0]  pc1;
    logic         valid0;
    logic         valid1;
    logic         nothing_filled;
    fetch_state_t dbg_state;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req_valid     (imem_req_valid),
        .imem_req_addr      (imem_req_addr),
        .imem_req_ready     (imem_req_ready),
        .imem_resp_valid    (imem_resp_valid),
        .imem_resp_data     (imem_resp_data),
        .flush              (flush),
        .flush_pc           (flush_pc),
        .freeze1            (freeze1),
        .freeze2            (freeze2),
        .dependency_on_ins2 (dependency_on_ins2),
        .instruction0       (instruction0),
        .instruction1       (instruction1),
        .pc0                (pc0),
        .pc1                (pc1),
        .valid0             (valid0),
        .valid1             (valid1),
        .nothing_filled     (nothing_filled),
        .o_dbg_state        (dbg_state)
    );

    // Reference model: buffered entries, in-flight count, PCs, drain flag.
    ent_t        mq[$];
    req_t        memq[$];
    int          m_out;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    bit          m_drain;
    int          cyc;
    int          lat;
    int          n_tests;
    int          n_fail;

    logic        e_valid0, e_valid1, e_empty, e_req_valid;
    logic [31:0] e_pc0, e_ins0, e_pc1, e_ins1, e_req_addr;

    function automatic void model_eval();
        e_valid0    = (mq.size() >= 1);
        e_valid1    = (mq.size() >= 2);
        e_empty     = (mq.size() == 0);
        e_pc0       = e_valid0 ? mq[0].pc    : 32'h0;
        e_ins0      = e_valid0 ? mq[0].instr : 32'h0;
        e_pc1       = e_valid1 ? mq[1].pc    : 32'h0;
        e_ins1      = e_valid1 ? mq[1].instr : 32'h0;
        e_req_valid = !rst && !flush && !m_drain && ((mq.size() + m_out) < DEPTH);
        e_req_addr  = m_fetch_pc;
    endfunction

    function automatic vec_t got_vec();
        return {valid0, valid1, nothing_filled, imem_req_valid, pc0, instruction0,
                pc1, instruction1, imem_req_valid ? imem_req_addr : 32'h0};
    endfunction

    function automatic vec_t exp_vec();
        return {e_valid0, e_valid1, e_empty, e_req_valid, e_pc0, e_ins0,
                e_pc1, e_ins1, e_req_valid ? e_req_addr : 32'h0};
    endfunction

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Advance one clock: update the model from this cycle's inputs, then let
    // the memory model drive the response for the next cycle.
    task automatic tick();
        bit          fire_m, fire_dut, p0, p1, was_rst;
        logic [31:0] addr;
        was_rst  = rst;
        fire_m   = e_req_valid && imem_req_ready;
        fire_dut = imem_req_valid && imem_req_ready;
        addr     = imem_req_addr;
        assert (rst || !(imem_resp_valid && m_out == 0))
            else $error("protocol: response with nothing outstanding");
        if (rst) begin
            mq.delete();
            m_out      = 0;
            m_fetch_pc = RESET_PC;
            m_resp_pc  = RESET_PC;
            m_drain    = 1'b0;
        end else if (flush) begin
            if (imem_resp_valid && m_out > 0) m_out--;
            mq.delete();
            m_fetch_pc = flush_pc & ~32'h3;
            m_resp_pc  = flush_pc & ~32'h3;
            m_drain    = (m_out != 0);
        end else begin
            p0 = (mq.size() >= 1) && !freeze1;
            p1 = p0 && (mq.size() >= 2) && !freeze2 && !dependency_on_ins2;
            if (p0) void'(mq.pop_front());
            if (p1) void'(mq.pop_front());
            if (imem_resp_valid && m_out > 0) begin
                m_out--;
                if (!m_drain) begin
                    mq.push_back('{pc: m_resp_pc, instr: imem_resp_data});
                    m_resp_pc += 32'd4;
                end
            end
            if (m_drain && m_out == 0) m_drain = 1'b0;
            if (fire_m) begin
                m_out++;
                m_fetch_pc += 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (was_rst) memq.delete();
        else if (fire_dut) memq.push_back('{addr: addr, due: cyc + lat - 1});
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memq[0].addr;
            void'(memq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
        end
        settle();
        n_tests++;
        if ({valid0, nothing_filled, imem_req_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_state got v0/empty/req=%b expected 010",
                     {valid0, nothing_filled, imem_req_valid});
        end
        n_tests++;
        if ({pc0, instruction0, pc1, instruction1} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h expected all zero", {pc0, instruction0, pc1, instruction1});
        end
        tick();
        rst = 1'b0;
        settle();
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_request got valid=%b addr=%h expected 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        logic [31:0] next_ret = RESET_PC;
        lat = 1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i != 0) settle();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream_cycle%0d got %h expected %h", i, got_vec(), exp_vec());
            end
            if (valid0) begin
                n_tests++;
                if (pc0 !== next_ret || instruction0 !== next_ret) begin
                    n_fail++;
                    $display("FAIL stream_retire0 got pc=%h ins=%h expected %h", pc0, instruction0, next_ret);
                end
                next_ret += 4;
                if (valid1) begin
                    n_tests++;
                    if (pc1 !== next_ret || instruction1 !== next_ret) begin
                        n_fail++;
                        $display("FAIL stream_retire1 got pc=%h ins=%h expected %h", pc1, instruction1, next_ret);
                    end
                    next_ret += 4;
                end
            end
            tick();
        end
    endtask

    task automatic test_freeze();
        logic [31:0] next_ret;
        freeze1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            settle();
            tick();
        end
        settle();
        n_tests++;
        if ({valid0, valid1, imem_req_valid} !== 3'b110 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL freeze_saturate got %h expected %h", got_vec(), exp_vec());
        end
        n_tests++;
        if (mq.size() != DEPTH || m_out != 0) begin
            n_fail++;
            $display("FAIL freeze_model_full got count=%0d out=%0d expected %0d 0", mq.size(), m_out, DEPTH);
        end
        next_ret = pc0;
        tick();
        freeze1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL release_cycle%0d got %h expected %h", i, got_vec(), exp_vec());
            end
            if (valid0) begin
                n_tests++;
                if (pc0 !== next_ret || (valid1 && pc1 !== next_ret + 4)) begin
                    n_fail++;
                    $display("FAIL release_order got pc0=%h pc1=%h expected %h", pc0, pc1, next_ret);
                end
                next_ret += valid1 ? 32'd8 : 32'd4;
            end
            tick();
        end
    endtask

    task automatic test_dependency();
        logic [31:0] old_pc1;
        bit          seen = 1'b0;
        freeze1 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            settle();
            if (valid1) seen = 1'b1;
            else tick();
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL dep_setup got valid1=%b expected 1 within budget", valid1);
        end
        freeze1 = 1'b0;
        dependency_on_ins2 = 1'b1;
        settle();
        old_pc1 = pc1;
        tick();
        dependency_on_ins2 = 1'b0;
        settle();
        n_tests++;
        if (pc0 !== old_pc1 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL dep_single_retire got pc0=%h expected %h", pc0, old_pc1);
        end
    endtask

    task automatic test_flush();
        bit found = 1'b0;
        lat = 4;
        for (int i = 0; i < 30 && !found; i++) begin
            settle();
            if (m_out == 3) found = 1'b1;
            else tick();
        end
        flush    = 1'b1;
        flush_pc = 32'h0000_0103;
        settle();
        n_tests++;
        if (!found || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle got req_valid=%b setup=%0d expected 0 1", imem_req_valid, found);
        end
        tick();
        flush = 1'b0;
        settle();
        n_tests++;
        if (nothing_filled !== 1'b1 || dbg_state !== DRAIN || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drain got empty=%b state=%0d req=%b expected 1 1 0",
                     nothing_filled, dbg_state, imem_req_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (i != 0) settle();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL flush_track%0d got %h expected %h", i, got_vec(), exp_vec());
            end
            if (valid0) found = 1'b1;
            else tick();
        end
        n_tests++;
        if (!found || pc0 !== 32'h100 || instruction0 !== 32'h100) begin
            n_fail++;
            $display("FAIL flush_first_pc got pc0=%h ins=%h expected 00000100", pc0, instruction0);
        end
        lat = 1;
    endtask

    task automatic test_flush_collision();
        bit found = 1'b0;
        lat = 1;
        for (int i = 0; i < 30 && !found; i++) begin
            settle();
            if (imem_resp_valid && valid0) found = 1'b1;
            else tick();
        end
        flush    = 1'b1;
        flush_pc = 32'h0000_0200;
        settle();
        n_tests++;
        if (!found || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_no_req got req_valid=%b setup=%0d expected 0 1", imem_req_valid, found);
        end
        tick();
        flush = 1'b0;
        settle();
        n_tests++;
        if (nothing_filled !== 1'b1 || valid0 !== 1'b0 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL collide_empty got %h expected %h", got_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_rst_mid();
        bit found = 1'b0;
        freeze1 = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            settle();
            if (mq.size() == 5) found = 1'b1;
            else tick();
        end
        rst = 1'b1;
        settle();
        n_tests++;
        if (!found || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_req got req_valid=%b setup=%0d expected 0 1", imem_req_valid, found);
        end
        tick();
        settle();
        n_tests++;
        if (valid0 !== 1'b0 || nothing_filled !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_empty got v0=%b empty=%b expected 0 1", valid0, nothing_filled);
        end
        tick();
        rst     = 1'b0;
        freeze1 = 1'b0;
        settle();
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_mid_restart got valid=%b addr=%h expected 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready     = ($urandom_range(0, 3) != 0);
            freeze1            = ($urandom_range(0, 3) == 0);
            freeze2            = ($urandom_range(0, 3) == 0);
            dependency_on_ins2 = ($urandom_range(0, 4) == 0);
            flush              = ($urandom_range(0, 39) == 0);
            flush_pc           = $urandom;
            if (memq.size() == 0) lat = $urandom_range(1, 3);
            settle();
            n_tests++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h expected %h", i, got_vec(), exp_vec());
            end
            tick();
        end
        flush = 1'b0;
        freeze1 = 1'b0;
        freeze2 = 1'b0;
        dependency_on_ins2 = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        imem_req_ready     = 1'b1;
        imem_resp_valid    = 1'b0;
        imem_resp_data     = 32'h0;
        flush              = 1'b0;
        flush_pc           = 32'h0;
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        m_out              = 0;
        m_fetch_pc         = RESET_PC;
        m_resp_pc          = RESET_PC;
        m_drain            = 1'b0;
        cyc                = 0;
        lat                = 1;
        n_tests            = 0;
        n_fail             = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_freeze();
        test_dependency();
        test_flush();
        test_flush_collision();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
